flags_stack: RTL and testbench
==============================

// Module: flags_stack
// PURPOSE
//  Parametrised ALU status-flag unit. Holds carry (cy) and overflow (ov) registers,
//  derives zero/sign from the accumulator, and adds a DEPTH-entry LIFO of {cy,ov}
//  for save/restore around interrupts and calls. Sits beside the accumulator in the
//  datapath; the control unit drives ce_cy/push/pop.
// PARAMETERS
//  WIDTH  8  accumulator width in bits (>=2)
//  DEPTH  4  flag-stack entries (>=1); pointer width = $clog2(DEPTH+1)
// PORTS
//  clk     in   1                 clock, all state updates on rising edge
//  rst_n   in   1                 synchronous reset, active-low
//  ce_cy   in   1                 load cy_new/ov_new into cy/ov
//  cy_new  in   1                 next carry from ALU
//  ov_new  in   1                 next overflow from ALU
//  acc     in   WIDTH             accumulator value
//  push    in   1                 save current {cy,ov} on stack
//  pop     in   1                 restore {cy,ov} from stack top
//  cy      out  1                 carry flag (registered)
//  ov      out  1                 overflow flag (registered)
//  zf      out  1                 acc == 0 (combinational)
//  sf      out  1                 acc[WIDTH-1] (combinational)
//  level   out  $clog2(DEPTH+1)   entries in use (registered)
//  full    out  1                 level == DEPTH
//  empty   out  1                 level == 0
//  err     out  1                 sticky stack-fault flag (registered)
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): cy=0, ov=0, level=0, err=0; stack contents don't-care.
//    Reset overrides all other inputs in the same cycle.
//  - zf/sf: pure combinational from acc, zero latency, unaffected by reset.
//  - Priority per cycle, evaluated on pre-edge values:
//    1. push&pop, level>0: swap - stack[top] <= {cy,ov}; {cy,ov} <= stack[top];
//       level unchanged; ce_cy ignored.
//    2. push&pop, level==0: err<=1; nothing else changes except ce_cy load.
//    3. pop only, level>0: {cy,ov} <= stack[top]; level-1; ce_cy ignored.
//    4. pop only, level==0: err<=1; ce_cy load still applies.
//    5. push only, level<DEPTH: stack[level] <= {cy,ov} (pre-update value);
//       level+1; ce_cy load applies in same cycle.
//    6. push only, full: err<=1; level/stack unchanged; ce_cy load applies.
//    7. neither: ce_cy=1 loads cy<=cy_new, ov<=ov_new; else hold.
//  - Latency: any flag/level/err change visible 1 cycle after the driving edge.
//  - err is sticky; cleared only by reset.
//  - full/empty combinational from registered level.
// CONFIGURATION
//  FLAGS_STICKY_OV_EN defined: extra ports clr_so (in,1) and so (out,1, reset 0).
//   so <= 1 on any edge where ov is loaded with 1 (ce_cy load or pop/swap restore);
//   clr_so=1 clears so; set wins over clear in same cycle. so is not stacked.
//  Not defined: ports clr_so/so absent; no sticky-overflow logic.
// TESTING
//  1. rst_n=0 one cycle, then acc=0 -> cy=0, ov=0, level=0, empty=1, err=0, zf=1, sf=0.
//  2. ce_cy cy_new=1 ov_new=0, then push, then ce_cy cy_new=0 ov_new=1, then pop
//     -> after pop cy=1, ov=0, level=0.
//  3. DEPTH=4: 5 pushes -> level=4, full=1 after 4th, err=1 after 5th, level stays 4.
//  4. pop at level=0 with ce_cy cy_new=1 -> err=1, cy=1, level=0.
//  5. level=1 top={0,1}, cy=1 ov=0, push&pop -> cy=0, ov=1, top={1,0}, level=1.
//  6. FLAGS_STICKY_OV_EN: ce_cy ov_new=1, then ov_new=0 -> so=1 held; clr_so -> so=0.

Source files
------------

// File: rtl/flags_stack.sv
// flags_stack: carry/overflow flag registers with zero/sign decode and a {cy,ov} save/restore LIFO (optional sticky overflow via FLAGS_STICKY_OV_EN)
module flags_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef FLAGS_STICKY_OV_EN
  input  logic          clr_so,
  output logic          so,
`endif
  input  logic          ce_cy,
  input  logic          cy_new,
  input  logic          ov_new,
  input  logic [WIDTH-1:0] acc,
  input  logic          push,
  input  logic          pop,
  output logic          cy,
  output logic          ov,
  output logic          zf,
  output logic          sf,
  output logic [PW-1:0] level,
  output logic          full,
  output logic          empty,
  output logic          err
);
  // sized to the full pointer range so any level value indexes it cleanly
  logic [1:0] stk [2**PW];
  logic [PW-1:0] top, wr_idx;
  logic restore, save, fault;
  assign top     = level - PW'(1);
  assign full    = level == PW'(DEPTH);
  assign empty   = level == '0;
  assign zf      = acc == '0;
  assign sf      = acc[WIDTH-1];
  assign restore = pop && !empty;
  assign save    = push && (pop ? !empty : !full);
  assign fault   = (pop && empty) || (push && !pop && full);
  assign wr_idx  = pop ? top : level;
  // stack storage: push writes at level, swap overwrites the top entry
  always_ff @(posedge clk) begin
    if (save) stk[wr_idx] <= {cy, ov};
  end
  // flags, level and sticky fault; a restore from the stack takes precedence over ce_cy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cy    <= 1'b0;
      ov    <= 1'b0;
      level <= '0;
      err   <= 1'b0;
    end else begin
      if (restore) {cy, ov} <= stk[top];
      else if (ce_cy) {cy, ov} <= {cy_new, ov_new};
      if (fault) err <= 1'b1;
      if (save && !pop) level <= level + PW'(1);
      else if (restore && !push) level <= level - PW'(1);
    end
  end
`ifdef FLAGS_STICKY_OV_EN
  logic ov_set;
  assign ov_set = restore ? stk[top][0] : ce_cy && ov_new;
  // sticky overflow: any write of ov=1 sets it, and setting beats clearing
  always_ff @(posedge clk) begin
    if (!rst_n) so <= 1'b0;
    else if (ov_set) so <= 1'b1;
    else if (clr_so) so <= 1'b0;
  end
`endif
endmodule

// File: tb/tb_flags_stack.sv
// tb_flags_stack: directed and random stimulus with a reference model feeding an expected-value queue
module tb_flags_stack;
  logic clk = 1'b0;
  logic rst_n, ce_cy, cy_new, ov_new, push, pop, clr_so;
  logic [7:0] acc;
  logic cy, ov, zf, sf, full, empty, err, so;
  logic [2:0] level;
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic cy, ov;
    logic [2:0] lvl;
    logic full, empty, err, zf, sf, so;
  } exp_t;
  exp_t sb [$];

  logic m_cy, m_ov, m_err, m_so;
  int m_lvl;
  logic [1:0] m_stk [4];

  flags_stack #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef FLAGS_STICKY_OV_EN
    .clr_so(clr_so), .so(so),
`endif
    .ce_cy(ce_cy), .cy_new(cy_new), .ov_new(ov_new), .acc(acc),
    .push(push), .pop(pop), .cy(cy), .ov(ov), .zf(zf), .sf(sf),
    .level(level), .full(full), .empty(empty), .err(err)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [3:0] o, input logic [3:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic push_exp(input logic [7:0] a);
    exp_t e;
    e.cy = m_cy; e.ov = m_ov; e.lvl = 3'(m_lvl);
    e.full = (m_lvl == 4); e.empty = (m_lvl == 0); e.err = m_err;
    e.zf = (a == 8'd0); e.sf = a[7]; e.so = m_so;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      cmp("scoreboard_underflow", 4'd1, 4'd0);
      return;
    end
    e = sb.pop_front();
    cmp("cy", {3'd0, cy}, {3'd0, e.cy});
    cmp("ov", {3'd0, ov}, {3'd0, e.ov});
    cmp("level", {1'b0, level}, {1'b0, e.lvl});
    cmp("full", {3'd0, full}, {3'd0, e.full});
    cmp("empty", {3'd0, empty}, {3'd0, e.empty});
    cmp("err", {3'd0, err}, {3'd0, e.err});
    cmp("zf", {3'd0, zf}, {3'd0, e.zf});
    cmp("sf", {3'd0, sf}, {3'd0, e.sf});
`ifdef FLAGS_STICKY_OV_EN
    cmp("so", {3'd0, so}, {3'd0, e.so});
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0; push = 1'b1; pop = 1'b0; ce_cy = 1'b1; cy_new = 1'b1; ov_new = 1'b1;
    clr_so = 1'b0; acc = 8'd0;
    m_cy = 0; m_ov = 0; m_err = 0; m_so = 0; m_lvl = 0;
    push_exp(acc);
    @(posedge clk); #1;
    check_out();
    rst_n = 1'b1;
  endtask

  task automatic step(input bit p, input bit q, input bit c, input bit cn, input bit on,
                      input bit clr, input logic [7:0] a);
    logic [1:0] t;
    logic ovs;
    push = p; pop = q; ce_cy = c; cy_new = cn; ov_new = on; clr_so = clr; acc = a;
    ovs = 1'b0;
    if (p && q) begin
      if (m_lvl > 0) begin
        t = m_stk[m_lvl-1]; m_stk[m_lvl-1] = {m_cy, m_ov}; {m_cy, m_ov} = t; ovs = t[0];
      end else begin
        m_err = 1;
        if (c) begin {m_cy, m_ov} = {cn, on}; ovs = on; end
      end
    end else if (q) begin
      if (m_lvl > 0) begin
        {m_cy, m_ov} = m_stk[m_lvl-1]; ovs = m_ov; m_lvl--;
      end else begin
        m_err = 1;
        if (c) begin {m_cy, m_ov} = {cn, on}; ovs = on; end
      end
    end else if (p) begin
      if (m_lvl < 4) begin m_stk[m_lvl] = {m_cy, m_ov}; m_lvl++; end
      else m_err = 1;
      if (c) begin {m_cy, m_ov} = {cn, on}; ovs = on; end
    end else if (c) begin
      {m_cy, m_ov} = {cn, on}; ovs = on;
    end
    if (ovs) m_so = 1;
    else if (clr) m_so = 0;
    push_exp(a);
    @(posedge clk); #1;
    check_out();
  endtask

  initial begin
    do_reset();
    acc = 8'h80; #1;
    cmp("zf_comb", {3'd0, zf}, 4'd0);
    cmp("sf_comb", {3'd0, sf}, 4'd1);
    acc = 8'h00; #1;
    cmp("zf_comb0", {3'd0, zf}, 4'd1);
    // carry saved across a clobbering load and restored by pop
    step(0, 0, 1, 1, 0, 0, 8'h01);
    step(1, 0, 0, 0, 0, 0, 8'h7f);
    step(0, 0, 1, 0, 1, 0, 8'hff);
    step(0, 1, 0, 0, 0, 0, 8'h00);
    // fill to DEPTH, then overflow
    for (int i = 0; i < 5; i++) step(1, 0, 1, i[0], i[1], 0, 8'(i));
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0, 8'h10);
    do_reset();
    // pop on empty still honours ce_cy
    step(0, 1, 1, 1, 0, 0, 8'h00);
    do_reset();
    // swap at level 1, then empty push&pop fault with load
    step(0, 0, 1, 0, 1, 0, 8'h00);
    step(1, 0, 1, 1, 0, 0, 8'h00);
    step(1, 1, 1, 0, 0, 0, 8'h00);
    step(0, 1, 0, 0, 0, 0, 8'h00);
    step(1, 1, 1, 1, 1, 0, 8'h55);
    do_reset();
    // sticky overflow sequence
    step(0, 0, 1, 0, 1, 0, 8'h00);
    step(0, 0, 1, 0, 0, 0, 8'h00);
    step(0, 0, 0, 0, 0, 1, 8'h00);
    step(0, 0, 1, 0, 1, 1, 8'h00);
    do_reset();
    for (int i = 0; i < 80; i++)
      step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom_range(0, 3) == 0), 8'($urandom_range(0, 3) == 0 ? 0 : $urandom));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
